// File: rtl/exec_pkg.sv
// Shared types for the execute stage.
//   op_class_e : top-level op class selecting which unit produces the result
//   alu_op_e   : ALU function codes (11-15 unused, reported as illegal)
//   br_type_e  : branch compare codes (funct3; 2 and 3 are never taken)
//   md_op_e    : multiply/divide codes (funct3)
//   state_e    : execute FSM states
package exec_pkg;
  localparam int XLEN_DEF = 32;

  typedef enum logic [1:0] {OC_ALU = 2'd0, OC_BRANCH = 2'd1, OC_JUMP = 2'd2, OC_MULDIV = 2'd3} op_class_e;

  typedef enum logic [3:0] {
    ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_AND = 4'd2, ALU_OR = 4'd3, ALU_XOR = 4'd4,
    ALU_SLL = 4'd5, ALU_SRL = 4'd6, ALU_SRA = 4'd7, ALU_SLT = 4'd8, ALU_SLTU = 4'd9,
    ALU_PASSB = 4'd10
  } alu_op_e;

  typedef enum logic [2:0] {
    BR_EQ = 3'd0, BR_NE = 3'd1, BR_LT = 3'd4, BR_GE = 3'd5, BR_LTU = 3'd6, BR_GEU = 3'd7
  } br_type_e;

  typedef enum logic [2:0] {
    MD_MUL = 3'd0, MD_MULH = 3'd1, MD_MULHSU = 3'd2, MD_MULHU = 3'd3,
    MD_DIV = 3'd4, MD_DIVU = 3'd5, MD_REM = 3'd6, MD_REMU = 3'd7
  } md_op_e;

  typedef enum logic {ST_IDLE = 1'b0, ST_CALC = 1'b1} state_e;
endpackage

// File: rtl/exec_muldiv_iter.sv
// Iterative multiply/divide unit, one bit per cycle over XLEN cycles.
// Signed ops run on operand magnitudes; the sign is applied to the final value.
//   clk, rst  : clock, synchronous active-high reset
//   start_i   : load operands and begin (ignored callers must not pulse while busy)
//   op_i      : md_op_e code
//   a_i, b_i  : rs1 / rs2 values
//   done_o    : high during the last iteration cycle; result_o is valid then
//   result_o  : signed-corrected result of the op in flight
// Division by zero and signed overflow are resolved by the caller, never started here.
module exec_muldiv_iter
  import exec_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start_i,
  input  logic [2:0]      op_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  output logic            done_o,
  output logic [XLEN-1:0] result_o
);
  localparam int CW = $clog2(XLEN);

  logic            busy_q, is_div_q, sel_hi_q, neg_q;
  logic [CW-1:0]   cnt_q;
  logic [XLEN-1:0] d_q;
  logic [2*XLEN-1:0] acc_q, acc_n, prod;

  logic a_sgn, b_sgn, a_neg, b_neg;
  logic [XLEN-1:0] a_mag, b_mag, half;
  logic [XLEN:0]   sum, rs, diff;

  assign a_sgn = (op_i == MD_MUL) | (op_i == MD_MULH) | (op_i == MD_MULHSU) |
                 (op_i == MD_DIV) | (op_i == MD_REM);
  assign b_sgn = (op_i == MD_MUL) | (op_i == MD_MULH) | (op_i == MD_DIV) | (op_i == MD_REM);
  assign a_neg = a_sgn & a_i[XLEN-1];
  assign b_neg = b_sgn & b_i[XLEN-1];
  assign a_mag = a_neg ? -a_i : a_i;
  assign b_mag = b_neg ? -b_i : b_i;

  // Multiply: acc = {partial product, remaining multiplier}, shift right each step.
  assign sum = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, d_q} : '0);
  // Divide (restoring): acc = {remainder, dividend/quotient}, shift left each step.
  assign rs   = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
  assign diff = rs - {1'b0, d_q};

  always_comb begin
    if (!is_div_q)     acc_n = {sum, acc_q[XLEN-1:1]};
    else if (diff[XLEN]) acc_n = {rs[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
    else               acc_n = {diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
  end

  // Result is taken from the post-step value so it can be registered on the final edge.
  assign prod = neg_q ? -acc_n : acc_n;
  assign half = sel_hi_q ? acc_n[2*XLEN-1:XLEN] : acc_n[XLEN-1:0];
  always_comb begin
    if (is_div_q) result_o = neg_q ? -half : half;
    else          result_o = sel_hi_q ? prod[2*XLEN-1:XLEN] : prod[XLEN-1:0];
  end

  assign done_o = busy_q & (cnt_q == CW'(XLEN-1));

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
    end else if (start_i) begin
      busy_q <= 1'b1;
      cnt_q  <= '0;
    end else if (busy_q) begin
      cnt_q <= cnt_q + 1'b1;
      if (done_o) busy_q <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (start_i) begin
      is_div_q <= op_i[2];
      // High half for MULH*; remainder half for REM*.
      sel_hi_q <= op_i[2] ? op_i[1] : (op_i[1:0] != 2'd0);
      // Remainder takes the dividend's sign; everything else the product of signs.
      neg_q    <= (op_i[2] & op_i[1]) ? a_neg : (a_neg ^ b_neg);
      d_q      <= b_mag;
      acc_q    <= {{XLEN{1'b0}}, a_mag};
    end else if (busy_q) begin
      acc_q <= acc_n;
    end
  end
endmodule

// File: rtl/exec_stage_pipe.sv
// RV32IM execute stage: single-cycle ALU/branch/jump plus optional iterative
// multiply/divide, with a result register held until the consumer takes it.
// Optional feature macro: EXEC_MULDIV_EN (undefined: MULDIV ops report illegal).
//   clk, rst            : clock, synchronous active-high reset
//   i_valid / o_ready   : upstream handshake
//   i_op_class .. i_rd_tag : decoded op and operands
//   o_valid / i_ready   : downstream handshake on the result register
//   o_result, o_redirect, o_target, o_rd_tag, o_illegal : registered result
//   o_busy              : iterative op in flight
module exec_stage_pipe
  import exec_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [1:0]       i_op_class,
  input  logic [3:0]       i_alu_ctrl,
  input  logic             i_alu_src,
  input  logic             i_alu_a_sel,
  input  logic [2:0]       i_branch_type,
  input  logic             i_jalr,
  input  logic [2:0]       i_md_op,
  input  logic [XLEN-1:0]  i_pc,
  input  logic [XLEN-1:0]  i_rs1_data,
  input  logic [XLEN-1:0]  i_rs2_data,
  input  logic [XLEN-1:0]  i_immediate,
  input  logic [TAG_W-1:0] i_rd_tag,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [XLEN-1:0]  o_result,
  output logic             o_redirect,
  output logic [XLEN-1:0]  o_target,
  output logic [TAG_W-1:0] o_rd_tag,
  output logic             o_illegal,
  output logic             o_busy
);
  localparam int SHW = $clog2(XLEN);

  state_e           state_q, state_d;
  logic             valid_q, valid_d, redir_q, redir_d, ill_q, ill_d;
  logic [XLEN-1:0]  res_q, res_d, tgt_q, tgt_d;
  logic [TAG_W-1:0] tag_q, tag_d;

  logic            accept, retire, alu_ill, taken, sc_redir, sc_ill, md_start, md_done, md_ill;
  logic [XLEN-1:0] op_a, op_b, pc_imm, alu_res, jmp_tgt, sc_res, sc_tgt, md_result, md_sp_res;
  logic [SHW-1:0]  shamt;

  assign o_ready = (state_q == ST_IDLE) & (!valid_q | i_ready);
  assign accept  = i_valid & o_ready;
  assign retire  = valid_q & i_ready;

  assign op_a    = i_alu_a_sel ? i_pc : i_rs1_data;
  assign op_b    = i_alu_src ? i_immediate : i_rs2_data;
  assign shamt   = op_b[SHW-1:0];
  assign pc_imm  = i_pc + i_immediate;
  assign jmp_tgt = i_jalr ? ((i_rs1_data + i_immediate) & ~XLEN'(1)) : pc_imm;

  always_comb begin
    alu_res = '0;
    alu_ill = 1'b0;
    case (alu_op_e'(i_alu_ctrl))
      ALU_ADD:   alu_res = op_a + op_b;
      ALU_SUB:   alu_res = op_a - op_b;
      ALU_AND:   alu_res = op_a & op_b;
      ALU_OR:    alu_res = op_a | op_b;
      ALU_XOR:   alu_res = op_a ^ op_b;
      ALU_SLL:   alu_res = op_a << shamt;
      ALU_SRL:   alu_res = op_a >> shamt;
      ALU_SRA:   alu_res = $unsigned($signed(op_a) >>> shamt);
      ALU_SLT:   alu_res = XLEN'($signed(op_a) < $signed(op_b));
      ALU_SLTU:  alu_res = XLEN'(op_a < op_b);
      ALU_PASSB: alu_res = op_b;
      default:   alu_ill = 1'b1;
    endcase
  end

  always_comb begin
    taken = 1'b0;
    case (br_type_e'(i_branch_type))
      BR_EQ:   taken = (i_rs1_data == i_rs2_data);
      BR_NE:   taken = (i_rs1_data != i_rs2_data);
      BR_LT:   taken = ($signed(i_rs1_data) <  $signed(i_rs2_data));
      BR_GE:   taken = ($signed(i_rs1_data) >= $signed(i_rs2_data));
      BR_LTU:  taken = (i_rs1_data <  i_rs2_data);
      BR_GEU:  taken = (i_rs1_data >= i_rs2_data);
      default: taken = 1'b0;
    endcase
  end

`ifdef EXEC_MULDIV_EN
  logic div_zero, div_ovf, md_special;
  assign div_zero   = (i_rs2_data == '0);
  // Signed DIV/REM have funct3[0]==0.
  assign div_ovf    = !i_md_op[0] && (i_rs1_data == {1'b1, {(XLEN-1){1'b0}}}) && (&i_rs2_data);
  assign md_special = i_md_op[2] & (div_zero | div_ovf);
  assign md_sp_res  = div_zero ? (i_md_op[1] ? i_rs1_data : '1)
                               : (i_md_op[1] ? '0 : i_rs1_data);
  assign md_start   = (i_op_class == OC_MULDIV) & !md_special;
  assign md_ill     = 1'b0;

  exec_muldiv_iter #(.XLEN(XLEN)) u_md (
    .clk      (clk),
    .rst      (rst),
    .start_i  (accept & md_start),
    .op_i     (i_md_op),
    .a_i      (i_rs1_data),
    .b_i      (i_rs2_data),
    .done_o   (md_done),
    .result_o (md_result)
  );
`else
  logic unused_md;
  assign unused_md = ^i_md_op;
  assign md_sp_res = '0;
  assign md_start  = 1'b0;
  assign md_done   = 1'b0;
  assign md_result = '0;
  assign md_ill    = 1'b1;
`endif

  // Result of any op that completes on its accept edge.
  always_comb begin
    sc_res   = '0;
    sc_redir = 1'b0;
    sc_tgt   = '0;
    sc_ill   = 1'b0;
    case (op_class_e'(i_op_class))
      OC_ALU:    begin sc_res = alu_ill ? '0 : alu_res; sc_ill = alu_ill; end
      OC_BRANCH: begin sc_redir = taken; sc_tgt = pc_imm; end
      OC_JUMP:   begin sc_res = i_pc + XLEN'(4); sc_redir = 1'b1; sc_tgt = jmp_tgt; end
      default:   begin sc_res = md_sp_res; sc_ill = md_ill; end
    endcase
  end

  always_comb begin
    state_d = state_q;
    valid_d = valid_q;
    res_d   = res_q;
    redir_d = redir_q;
    tgt_d   = tgt_q;
    tag_d   = tag_q;
    ill_d   = ill_q;
    if (retire) valid_d = 1'b0;
    case (state_q)
      ST_IDLE: if (accept) begin
        tag_d = i_rd_tag;
        if (md_start) begin
          state_d = ST_CALC;
        end else begin
          valid_d = 1'b1;
          res_d   = sc_res;
          redir_d = sc_redir;
          tgt_d   = sc_tgt;
          ill_d   = sc_ill;
        end
      end
      ST_CALC: if (md_done) begin
        state_d = ST_IDLE;
        valid_d = 1'b1;
        res_d   = md_result;
        redir_d = 1'b0;
        tgt_d   = '0;
        ill_d   = 1'b0;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      valid_q <= 1'b0;
      res_q   <= '0;
      redir_q <= 1'b0;
      tgt_q   <= '0;
      tag_q   <= '0;
      ill_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      res_q   <= res_d;
      redir_q <= redir_d;
      tgt_q   <= tgt_d;
      tag_q   <= tag_d;
      ill_q   <= ill_d;
    end
  end

  assign o_valid    = valid_q;
  assign o_result   = res_q;
  assign o_redirect = redir_q;
  assign o_target   = tgt_q;
  assign o_rd_tag   = tag_q;
  assign o_illegal  = ill_q;
  assign o_busy     = (state_q == ST_CALC);
endmodule
